// File: rtl/rej_sampler_stream.sv
`default_nettype none
// ============================================================================
// Module      : rej_sampler_stream
// Description : Streams a seed into SHAKE, then rejection-samples the squeeze
//               stream into packed polynomial coefficients (RejNTTPoly /
//               RejBoundedPoly).
// Revision    : 1.0 - initial release
// ============================================================================
module rej_sampler_stream #(
    parameter int DATA_IN_BITS    = 64,
    parameter int DATA_OUT_BITS   = 64,
    parameter int COEFF_WIDTH     = 24,
    parameter int COEFFS_PER_WORD = 4,
    parameter int N               = 256,
    parameter int SEED_MAX_BYTES  = 66
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   mode,
    input  logic                                   eta_sel,
    input  logic [SEED_MAX_BYTES*8-1:0]            seed,
    input  logic [6:0]                             seed_bytes,
    output logic                                   busy,
    output logic                                   done,
    output logic [DATA_IN_BITS-1:0]                ab_data,
    output logic                                   ab_valid,
    output logic                                   ab_last,
    output logic [$clog2(DATA_IN_BITS):0]          ab_last_len,
    input  logic                                   ab_ready,
    input  logic [DATA_OUT_BITS-1:0]               sq_data,
    input  logic                                   sq_valid,
    output logic                                   sq_ready,
    output logic [COEFF_WIDTH*COEFFS_PER_WORD-1:0] wr_data,
    output logic [$clog2(N/COEFFS_PER_WORD)-1:0]   wr_addr,
    output logic                                   wr_valid,
    input  logic                                   wr_ready
);

    localparam int c_SEED_W    = SEED_MAX_BYTES * 8;
    localparam int c_MAX_BEATS = (c_SEED_W + DATA_IN_BITS - 1) / DATA_IN_BITS;
    localparam int c_PAD_W     = c_MAX_BEATS * DATA_IN_BITS;
    localparam int c_BEAT_W    = $clog2(c_MAX_BEATS + 1);
    localparam int c_BUF_W     = DATA_OUT_BITS + 24;
    localparam int c_FILL_W    = $clog2(c_BUF_W + 1);
    localparam int c_WORD_W    = COEFF_WIDTH * COEFFS_PER_WORD;
    localparam int c_ADDR_W    = $clog2(N / COEFFS_PER_WORD);
    localparam int c_PACK_W    = $clog2(COEFFS_PER_WORD + 1);
    localparam int c_CNT_W     = $clog2(N + 1);
    localparam int c_LEN_W     = $clog2(DATA_IN_BITS) + 1;
    localparam logic [COEFF_WIDTH-1:0] c_Q = COEFF_WIDTH'(8380417);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ABSORB = 2'd1,
        S_RUN    = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t                state_q,      state_d;
    logic                  mode_q,       mode_d;
    logic                  eta_q,        eta_d;
    logic [c_PAD_W-1:0]    seed_q,       seed_d;
    logic [6:0]            seed_bytes_q, seed_bytes_d;
    logic [c_BEAT_W-1:0]   beat_q,       beat_d;
    logic [c_BUF_W-1:0]    buf_q,        buf_d;
    logic [c_FILL_W-1:0]   fill_q,       fill_d;
    logic [c_WORD_W-1:0]   pack_q,       pack_d;
    logic [c_PACK_W-1:0]   pack_cnt_q,   pack_cnt_d;
    logic [c_CNT_W-1:0]    coeff_cnt_q,  coeff_cnt_d;
    logic                  wr_valid_q,   wr_valid_d;
    logic [c_ADDR_W-1:0]   wr_addr_q,    wr_addr_d;
    logic                  done_q,       done_d;

    logic [c_SEED_W-1:0]    w_seed_mask;
    logic [15:0]            w_total_bits;
    logic [15:0]            w_nbeats;
    logic [15:0]            w_rem;
    logic                   w_last_beat;
    logic [c_FILL_W-1:0]    w_need;
    logic                   w_can_eval;
    logic                   w_load;
    logic                   w_accept;
    logic [COEFF_WIDTH-1:0] w_coeff;
    logic [22:0]            w_v;
    logic [3:0]             w_nib;
    logic [3:0]             w_r;
    logic [3:0]             w_eta;

    // Bytes beyond seed_bytes are zeroed at capture so the final beat pads with 0.
    always_comb begin
        w_seed_mask = '0;
        for (int b = 0; b < SEED_MAX_BYTES; b++) begin
            w_seed_mask[b*8 +: 8] = (b < int'(seed_bytes)) ? 8'hFF : 8'h00;
        end
    end

    assign w_total_bits = 16'(seed_bytes_q) << 3;
    assign w_nbeats     = (w_total_bits + 16'(DATA_IN_BITS - 1)) / 16'(DATA_IN_BITS);
    assign w_rem        = w_total_bits % 16'(DATA_IN_BITS);
    assign w_last_beat  = (16'(beat_q) + 16'd1) == w_nbeats;

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign ab_valid    = (state_q == S_ABSORB);
    assign ab_data     = ab_valid ? seed_q[beat_q*DATA_IN_BITS +: DATA_IN_BITS] : '0;
    assign ab_last     = ab_valid & w_last_beat;
    assign ab_last_len = !ab_valid        ? '0 :
                         (w_rem == 16'd0) ? c_LEN_W'(DATA_IN_BITS) : c_LEN_W'(w_rem);

    assign w_need     = mode_q ? c_FILL_W'(4) : c_FILL_W'(24);
    assign sq_ready   = (state_q == S_RUN) && (fill_q <  w_need) && !wr_valid_q;
    assign w_can_eval = (state_q == S_RUN) && (fill_q >= w_need) && !wr_valid_q;
    assign w_load     = sq_ready && sq_valid;

    assign wr_valid = wr_valid_q;
    assign wr_data  = wr_valid_q ? pack_q    : '0;
    assign wr_addr  = wr_valid_q ? wr_addr_q : '0;

    assign w_v   = buf_q[22:0];
    assign w_nib = buf_q[3:0];
    assign w_eta = eta_q ? 4'd4 : 4'd2;
    assign w_r   = eta_q ? w_nib : (w_nib % 4'd5);

    // Bounded value is eta - r; a negative result wraps to Q - (r - eta).
    always_comb begin
        w_accept = 1'b0;
        w_coeff  = '0;
        if (!mode_q) begin
            w_accept = COEFF_WIDTH'(w_v) < c_Q;
            w_coeff  = COEFF_WIDTH'(w_v);
        end else begin
            w_accept = eta_q ? (w_nib < 4'd9) : (w_nib < 4'd15);
            if (w_r <= w_eta) begin
                w_coeff = COEFF_WIDTH'(w_eta - w_r);
            end else begin
                w_coeff = c_Q - COEFF_WIDTH'(w_r - w_eta);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        eta_d        = eta_q;
        seed_d       = seed_q;
        seed_bytes_d = seed_bytes_q;
        beat_d       = beat_q;
        buf_d        = buf_q;
        fill_d       = fill_q;
        pack_d       = pack_q;
        pack_cnt_d   = pack_cnt_q;
        coeff_cnt_d  = coeff_cnt_q;
        wr_valid_d   = wr_valid_q;
        wr_addr_d    = wr_addr_q;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d       = mode;
                    eta_d        = eta_sel;
                    seed_d       = c_PAD_W'(seed & w_seed_mask);
                    seed_bytes_d = seed_bytes;
                    beat_d       = '0;
                    buf_d        = '0;
                    fill_d       = '0;
                    pack_d       = '0;
                    pack_cnt_d   = '0;
                    coeff_cnt_d  = '0;
                    wr_valid_d   = 1'b0;
                    wr_addr_d    = '0;
                    state_d      = S_ABSORB;
                end
            end

            S_ABSORB: begin
                if (ab_ready) begin
                    beat_d = beat_q + c_BEAT_W'(1);
                    if (w_last_beat) begin
                        state_d = S_RUN;
                    end
                end
            end

            S_RUN: begin
                if (w_load) begin
                    buf_d  = buf_q | (c_BUF_W'(sq_data) << fill_q);
                    fill_d = fill_q + c_FILL_W'(DATA_OUT_BITS);
                end else if (w_can_eval) begin
                    buf_d  = buf_q >> w_need;
                    fill_d = fill_q - w_need;
                    if (w_accept) begin
                        pack_d[pack_cnt_q*COEFF_WIDTH +: COEFF_WIDTH] = w_coeff;
                        coeff_cnt_d = coeff_cnt_q + c_CNT_W'(1);
                        if (pack_cnt_q == c_PACK_W'(COEFFS_PER_WORD - 1)) begin
                            pack_cnt_d = '0;
                            wr_valid_d = 1'b1;
                        end else begin
                            pack_cnt_d = pack_cnt_q + c_PACK_W'(1);
                        end
                        if (coeff_cnt_q == c_CNT_W'(N - 1)) begin
                            state_d = S_DRAIN;
                        end
                    end
                end
                if (wr_valid_q && wr_ready) begin
                    wr_valid_d = 1'b0;
                    wr_addr_d  = wr_addr_q + c_ADDR_W'(1);
                end
            end

            S_DRAIN: begin
                if (wr_valid_q && wr_ready) begin
                    wr_valid_d = 1'b0;
                    wr_addr_d  = wr_addr_q + c_ADDR_W'(1);
                    buf_d      = '0;
                    fill_d     = '0;
                    done_d     = 1'b1;
                    state_d    = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mode_q       <= 1'b0;
            eta_q        <= 1'b0;
            seed_q       <= '0;
            seed_bytes_q <= '0;
            beat_q       <= '0;
            buf_q        <= '0;
            fill_q       <= '0;
            pack_q       <= '0;
            pack_cnt_q   <= '0;
            coeff_cnt_q  <= '0;
            wr_valid_q   <= 1'b0;
            wr_addr_q    <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            eta_q        <= eta_d;
            seed_q       <= seed_d;
            seed_bytes_q <= seed_bytes_d;
            beat_q       <= beat_d;
            buf_q        <= buf_d;
            fill_q       <= fill_d;
            pack_q       <= pack_d;
            pack_cnt_q   <= pack_cnt_d;
            coeff_cnt_q  <= coeff_cnt_d;
            wr_valid_q   <= wr_valid_d;
            wr_addr_q    <= wr_addr_d;
            done_q       <= done_d;
        end
    end

endmodule
`default_nettype wire
